// File: rtl/tcp_tx_sched_if.sv
// Handshake bundle between the app enqueue side, the TX scheduler and TX control.
interface tcp_tx_sched_if #(
  parameter int unsigned FLOWID_W = 3
);
  logic                app_sched_enq_val;
  logic [FLOWID_W-1:0] app_sched_enq_flowid;
  logic                sched_app_enq_rdy;
  logic                sched_tx_req_val;
  logic [FLOWID_W-1:0] sched_tx_req_flowid;
  logic                tx_sched_req_rdy;
  logic                sched_tx_update_val;
  logic                sched_tx_update_requeue;
  logic                sched_tx_update_rdy;

  // master: app + TX control side; slave: the scheduler
  modport master (
    output app_sched_enq_val, app_sched_enq_flowid, tx_sched_req_rdy,
           sched_tx_update_val, sched_tx_update_requeue,
    input  sched_app_enq_rdy, sched_tx_req_val, sched_tx_req_flowid, sched_tx_update_rdy
  );

  modport slave (
    input  app_sched_enq_val, app_sched_enq_flowid, tx_sched_req_rdy,
           sched_tx_update_val, sched_tx_update_requeue,
    output sched_app_enq_rdy, sched_tx_req_val, sched_tx_req_flowid, sched_tx_update_rdy
  );
endinterface

// File: rtl/tcp_tx_sched.sv
// Round-robin TX scheduler: duplicate-free circular flow queue, one flow in flight at a time.
// Optional saturating statistics counters when TCP_TX_SCHED_STATS_EN is defined.
module tcp_tx_sched #(
  parameter int unsigned FLOWID_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  tcp_tx_sched_if.slave bus
`ifdef TCP_TX_SCHED_STATS_EN
  ,
  output logic [31:0]   stat_issue_cnt,
  output logic [31:0]   stat_dup_drop_cnt,
  output logic [31:0]   stat_requeue_cnt
`endif
);
  localparam int unsigned NUM_FLOWS = 1 << FLOWID_W;
  localparam int unsigned PTR_W     = FLOWID_W + 1;

  typedef enum logic {ST_IDLE, ST_WAIT_UPDATE} state_t;

  state_t state;
  state_t state_nxt;

  logic [FLOWID_W-1:0]  queue [NUM_FLOWS];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [NUM_FLOWS-1:0] in_queue;
  logic [NUM_FLOWS-1:0] pending;
  logic [FLOWID_W-1:0]  inflight_id;

  logic [FLOWID_W-1:0]  head_id;
  logic [FLOWID_W-1:0]  enq_id;
  logic [FLOWID_W-1:0]  push_id;
  logic                 empty;
  logic                 pop;
  logic                 upd_fire;
  logic                 upd_push;
  logic                 enq_hit_wait;
  logic                 enq_hit_pop;
  logic                 enq_acc;
  logic                 enq_pend;
  logic                 enq_push;
  logic                 push;

  // Handshake decode; an update push owns the single write port unless the enq merges into it
  always_comb begin
    head_id      = queue[head[FLOWID_W-1:0]];
    enq_id       = bus.app_sched_enq_flowid;
    empty        = (head == tail);
    pop          = (state == ST_IDLE) && !empty && bus.tx_sched_req_rdy;
    upd_fire     = (state == ST_WAIT_UPDATE) && bus.sched_tx_update_val;
    enq_hit_wait = (state == ST_WAIT_UPDATE) && (enq_id == inflight_id);
    enq_hit_pop  = pop && (enq_id == head_id);
    upd_push     = upd_fire && (bus.sched_tx_update_requeue || pending[inflight_id] ||
                                (bus.app_sched_enq_val && enq_hit_wait));
    bus.sched_app_enq_rdy = !upd_push || enq_hit_wait;
    enq_acc      = bus.app_sched_enq_val && bus.sched_app_enq_rdy;
    enq_pend     = enq_acc && ((enq_hit_wait && !upd_fire && !pending[inflight_id]) || enq_hit_pop);
    enq_push     = enq_acc && !enq_hit_wait && !enq_hit_pop && !in_queue[enq_id];
    push         = upd_push || enq_push;
    push_id      = upd_push ? inflight_id : enq_id;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (pop) state_nxt = ST_WAIT_UPDATE;
      ST_WAIT_UPDATE: if (bus.sched_tx_update_val) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.sched_tx_req_val    = 1'b0;
    bus.sched_tx_update_rdy = 1'b0;
    bus.sched_tx_req_flowid = head_id;
    case (state)
      ST_IDLE:        bus.sched_tx_req_val    = !empty;
      ST_WAIT_UPDATE: bus.sched_tx_update_rdy = 1'b1;
      default:        ;
    endcase
  end

  // Queue storage, pointers and per-flow bitmaps
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      in_queue    <= '0;
      pending     <= '0;
      inflight_id <= '0;
      for (int unsigned i = 0; i < NUM_FLOWS; i++) queue[i] <= '0;
    end else begin
      if (pop) begin
        head              <= head + PTR_W'(1);
        inflight_id       <= head_id;
        in_queue[head_id] <= 1'b0;
      end
      if (push) begin
        queue[tail[FLOWID_W-1:0]] <= push_id;
        tail                      <= tail + PTR_W'(1);
        in_queue[push_id]         <= 1'b1;
      end
      if (enq_pend) pending[enq_id]      <= 1'b1;
      if (upd_fire) pending[inflight_id] <= 1'b0;
    end
  end

`ifdef TCP_TX_SCHED_STATS_EN
  logic enq_dup;

  always_comb begin
    enq_dup = enq_acc && ((enq_hit_wait && pending[inflight_id]) ||
                          (!enq_hit_wait && !enq_hit_pop && in_queue[enq_id]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue_cnt    <= '0;
      stat_dup_drop_cnt <= '0;
      stat_requeue_cnt  <= '0;
    end else begin
      if (pop && (stat_issue_cnt != '1))         stat_issue_cnt    <= stat_issue_cnt + 32'd1;
      if (enq_dup && (stat_dup_drop_cnt != '1))  stat_dup_drop_cnt <= stat_dup_drop_cnt + 32'd1;
      if (upd_push && (stat_requeue_cnt != '1))  stat_requeue_cnt  <= stat_requeue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tcp_tx_sched.sv
// Self-checking bench for tcp_tx_sched: directed scenarios plus random traffic against a
// queue-based reference model of the scheduling rules.
module tb_tcp_tx_sched;
  localparam int unsigned FLOWID_W  = 3;
  localparam int unsigned NUM_FLOWS = 8;

  logic clk = 1'b0;
  logic rst;

  tcp_tx_sched_if #(.FLOWID_W(FLOWID_W)) bus ();

`ifdef TCP_TX_SCHED_STATS_EN
  logic [31:0] stat_issue_cnt, stat_dup_drop_cnt, stat_requeue_cnt;
  tcp_tx_sched #(.FLOWID_W(FLOWID_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stat_issue_cnt(stat_issue_cnt), .stat_dup_drop_cnt(stat_dup_drop_cnt),
    .stat_requeue_cnt(stat_requeue_cnt));
`else
  tcp_tx_sched #(.FLOWID_W(FLOWID_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO of waiting flows, single in-flight slot, pending flags
  int mq[$];
  bit busy;
  int inf;
  bit pend [NUM_FLOWS];
  int m_issue, m_drop, m_requeue;
  int issued[$];

  function automatic bit in_q(input int id);
    foreach (mq[i]) if (mq[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    busy = 1'b0;
    inf  = 0;
    foreach (pend[i]) pend[i] = 1'b0;
    m_issue = 0; m_drop = 0; m_requeue = 0;
  endfunction

  function automatic bit seq_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q2s(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  // One clock: drive inputs, capture observed/expected {req_val,req_flowid,upd_rdy,enq_rdy}, advance model
  task automatic cycle(input bit ev, input int eid, input bit rr, input bit uv, input bit rq,
                       output logic [5:0] obs, output logic [5:0] exp);
    bit e_rv, e_ur, e_er, upush, fire, ufire, eacc;
    int e_id, pid;
    bus.app_sched_enq_val       = ev;
    bus.app_sched_enq_flowid    = 3'(eid);
    bus.tx_sched_req_rdy        = rr;
    bus.sched_tx_update_val     = uv;
    bus.sched_tx_update_requeue = rq;
    #1;
    e_rv  = !busy && (mq.size() > 0);
    e_id  = e_rv ? mq[0] : 0;
    e_ur  = busy;
    upush = busy && uv && (rq || pend[inf] || (ev && eid == inf));
    e_er  = !upush || (busy && eid == inf);
    exp   = {e_rv, 3'(e_id), e_ur, e_er};
    obs   = {bus.sched_tx_req_val, bus.sched_tx_req_val ? bus.sched_tx_req_flowid : 3'd0,
             bus.sched_tx_update_rdy, bus.sched_app_enq_rdy};
    if (bus.sched_tx_req_val && rr) issued.push_back(int'(bus.sched_tx_req_flowid));
    @(posedge clk);
    fire  = e_rv && rr;
    ufire = busy && uv;
    eacc  = ev && e_er;
    pid   = -1;
    if (fire) pid = mq.pop_front();
    if (eacc) begin
      if (busy && eid == inf) begin
        if (pend[inf]) m_drop++;
        else if (!ufire) pend[inf] = 1'b1;
      end else if (eid == pid) pend[eid] = 1'b1;
      else if (in_q(eid)) m_drop++;
      else mq.push_back(eid);
    end
    if (ufire) begin
      if (upush) begin mq.push_back(inf); m_requeue++; end
      pend[inf] = 1'b0;
      busy      = 1'b0;
    end
    if (fire) begin busy = 1'b1; inf = pid; m_issue++; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.app_sched_enq_val = 1'b0; bus.app_sched_enq_flowid = '0; bus.tx_sched_req_rdy = 1'b0;
    bus.sched_tx_update_val = 1'b0; bus.sched_tx_update_requeue = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (bus.sched_tx_req_val !== 1'b0) begin bad++; $display("FAIL reset_req_val got=%b want=0", bus.sched_tx_req_val); end
    total++; if (bus.sched_tx_req_flowid !== 3'd0) begin bad++; $display("FAIL reset_flowid got=%0d want=0", bus.sched_tx_req_flowid); end
    total++; if (bus.sched_tx_update_rdy !== 1'b0) begin bad++; $display("FAIL reset_upd_rdy got=%b want=0", bus.sched_tx_update_rdy); end
    total++; if (bus.sched_app_enq_rdy !== 1'b1) begin bad++; $display("FAIL reset_enq_rdy got=%b want=1", bus.sched_app_enq_rdy); end
  endtask

  task automatic test_order();
    int ids[3] = '{2, 5, 1};
    int want[$] = '{2, 5, 1};
    logic [5:0] o, e;
    issued.delete();
    for (int i = 0; i < 14; i++) begin
      cycle(i < 3, (i < 3) ? ids[i] : 0, 1'b1, 1'b1, 1'b0, o, e);
      total++; if (o !== e) begin bad++; $display("FAIL order cyc=%0d got=%b want=%b", i, o, e); end
    end
    total++; if (!seq_eq(issued, want)) begin bad++; $display("FAIL order_seq got=%s want=%s", q2s(issued), q2s(want)); end
  endtask

  task automatic test_dup();
    int want[$] = '{3};
    logic [5:0] o, e;
`ifdef TCP_TX_SCHED_STATS_EN
    logic [31:0] d0 = stat_dup_drop_cnt;
`endif
    issued.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(i < 2, 3, i >= 2, 1'b1, 1'b0, o, e);
      total++; if (o !== e) begin bad++; $display("FAIL dup cyc=%0d got=%b want=%b", i, o, e); end
    end
    total++; if (!seq_eq(issued, want)) begin bad++; $display("FAIL dup_seq got=%s want=%s", q2s(issued), q2s(want)); end
`ifdef TCP_TX_SCHED_STATS_EN
    total++; if (stat_dup_drop_cnt - d0 !== 32'd1) begin bad++; $display("FAIL dup_stat got=%0d want=1", stat_dup_drop_cnt - d0); end
`endif
  endtask

  task automatic test_pending();
    int want[$] = '{4, 4};
    logic [5:0] o, e;
    issued.delete();
    // enq 4, issue 4, enq 4 while in flight, then update without requeue
    cycle(1'b1, 4, 1'b0, 1'b0, 1'b0, o, e);
    total++; if (o !== e) begin bad++; $display("FAIL pend_enq got=%b want=%b", o, e); end
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, o, e);
    total++; if (o !== e) begin bad++; $display("FAIL pend_issue got=%b want=%b", o, e); end
    cycle(1'b1, 4, 1'b1, 1'b0, 1'b0, o, e);
    total++; if (o !== e) begin bad++; $display("FAIL pend_reenq got=%b want=%b", o, e); end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b1, 1'b0, o, e);
      total++; if (o !== e) begin bad++; $display("FAIL pend cyc=%0d got=%b want=%b", i, o, e); end
    end
    total++; if (!seq_eq(issued, want)) begin bad++; $display("FAIL pend_seq got=%s want=%s", q2s(issued), q2s(want)); end
  endtask

  task automatic test_requeue();
    int want[$] = '{6, 7, 6};
    logic [5:0] o, e;
    issued.delete();
    cycle(1'b1, 6, 1'b0, 1'b0, 1'b0, o, e);
    cycle(1'b1, 7, 1'b0, 1'b0, 1'b0, o, e);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b1, issued.size() == 1, o, e);
      total++; if (o !== e) begin bad++; $display("FAIL rq cyc=%0d got=%b want=%b", i, o, e); end
    end
    total++; if (!seq_eq(issued, want)) begin bad++; $display("FAIL rq_seq got=%s want=%s", q2s(issued), q2s(want)); end
  endtask

  task automatic test_full();
    int want[$] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    logic [5:0] o, e;
    issued.delete();
    for (int i = 0; i < 8; i++) cycle(1'b1, i, 1'b0, 1'b0, 1'b0, o, e);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, o, e);
    // update push and enq of another flow collide: enq must be refused
    cycle(1'b1, 5, 1'b0, 1'b1, 1'b1, o, e);
    total++; if (o[0] !== 1'b0) begin bad++; $display("FAIL full_enq_block got=%b want=0", o[0]); end
    total++; if (o !== e) begin bad++; $display("FAIL full_coll got=%b want=%b", o, e); end
    cycle(1'b1, 5, 1'b1, 1'b0, 1'b0, o, e);
    total++; if (o[0] !== 1'b1) begin bad++; $display("FAIL full_enq_retry got=%b want=1", o[0]); end
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b1, 1'b0, o, e);
      total++; if (o !== e) begin bad++; $display("FAIL full cyc=%0d got=%b want=%b", i, o, e); end
    end
    total++; if (!seq_eq(issued, want)) begin bad++; $display("FAIL full_seq got=%s want=%s", q2s(issued), q2s(want)); end
`ifdef TCP_TX_SCHED_STATS_EN
    total++; if (stat_requeue_cnt !== 32'(m_requeue)) begin bad++; $display("FAIL full_stat_rq got=%0d want=%0d", stat_requeue_cnt, m_requeue); end
`endif
  endtask

  task automatic test_reset_mid();
    int want[$] = '{0};
    logic [5:0] o, e;
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 1'b0, 1'b0, 1'b0, o, e);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, o, e);
    bus.app_sched_enq_val = 1'b0; bus.tx_sched_req_rdy = 1'b0; bus.sched_tx_update_val = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (bus.sched_tx_req_val !== 1'b0) begin bad++; $display("FAIL rmid_req_val got=%b want=0", bus.sched_tx_req_val); end
    total++; if (bus.sched_tx_update_rdy !== 1'b0) begin bad++; $display("FAIL rmid_upd_rdy got=%b want=0", bus.sched_tx_update_rdy); end
    total++; if (bus.sched_app_enq_rdy !== 1'b1) begin bad++; $display("FAIL rmid_enq_rdy got=%b want=1", bus.sched_app_enq_rdy); end
    issued.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(i == 0, 0, 1'b1, 1'b1, 1'b0, o, e);
      total++; if (o !== e) begin bad++; $display("FAIL rmid cyc=%0d got=%b want=%b", i, o, e); end
    end
    total++; if (!seq_eq(issued, want)) begin bad++; $display("FAIL rmid_seq got=%s want=%s", q2s(issued), q2s(want)); end
  endtask

  task automatic test_random();
    logic [5:0] o, e;
    int eid;
    for (int i = 0; i < 600; i++) begin
      eid = (busy && $urandom_range(0, 3) == 0) ? inf : int'($urandom_range(0, NUM_FLOWS - 1));
      cycle($urandom_range(0, 1) == 1, eid, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, o, e);
      total++; if (o !== e) begin bad++; $display("FAIL rand cyc=%0d got=%b want=%b", i, o, e); end
    end
`ifdef TCP_TX_SCHED_STATS_EN
    total++; if (stat_issue_cnt !== 32'(m_issue)) begin bad++; $display("FAIL stat_issue got=%0d want=%0d", stat_issue_cnt, m_issue); end
    total++; if (stat_dup_drop_cnt !== 32'(m_drop)) begin bad++; $display("FAIL stat_drop got=%0d want=%0d", stat_dup_drop_cnt, m_drop); end
    total++; if (stat_requeue_cnt !== 32'(m_requeue)) begin bad++; $display("FAIL stat_rq got=%0d want=%0d", stat_requeue_cnt, m_requeue); end
`endif
  endtask

  initial begin
    test_reset();
    test_order();
    test_dup();
    test_pending();
    test_requeue();
    test_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
